// File: rtl/spi_rr_sched.sv
// ---------------------------------------------------------------------------
// spi_rr_sched
//
// Shares one serial packet-read engine between NREQ requesters. Pending
// requests are arbitrated round-robin. The winner's chip-select index and
// clock-scaler value are routed to the engine and one transfer is launched.
// The captured word is then handed back to the winner together with a
// one-cycle ack pulse. If the engine never reports completion, a watchdog
// ends the wait and the ack carries an error flag instead.
//
// Ports
//   clk         system clock, all logic on the rising edge
//   rst_n       asynchronous active-low reset
//   req         level request per requester, held until its ack
//   scaler_cfg  per-requester scaler, slice i = bits [i*W +: W]
//   ack         one-hot, one-cycle pulse: result for requester i is ready
//   rd_data     result word, valid while ack is non-zero (0 otherwise)
//   err         high with ack when the transfer timed out
//   eng_start   one-cycle launch pulse to the engine
//   eng_sel     chip-select route index, stable from eng_start to ack
//   eng_scaler  scaler routed to the engine, stable from eng_start to ack
//   eng_busy    engine is mid-transfer; blocks new grants
//   eng_done    one-cycle pulse from the engine: eng_data is valid
//   eng_data    word captured by the engine
//   sched_busy  high whenever the scheduler is not idle
// ---------------------------------------------------------------------------
module spi_rr_sched #(
    parameter int NREQ = 4,
    parameter int W    = 8,
    parameter int PKG  = 16,
    parameter int TMO  = 1024
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*W-1:0]         scaler_cfg,
    output logic [NREQ-1:0]           ack,
    output logic [PKG-1:0]            rd_data,
    output logic                      err,
    output logic                      eng_start,
    output logic [$clog2(NREQ)-1:0]   eng_sel,
    output logic [W-1:0]              eng_scaler,
    input  logic                      eng_busy,
    input  logic                      eng_done,
    input  logic [PKG-1:0]            eng_data,
    output logic                      sched_busy
);

    localparam int SW = $clog2(NREQ);
    // The watchdog has to be able to hold the value TMO itself.
    localparam int CW = $clog2(TMO + 1);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] LAUNCH  = 2'd1;
    localparam logic [1:0] WAIT    = 2'd2;
    localparam logic [1:0] DELIVER = 2'd3;

    localparam logic [NREQ-1:0] ONE_HOT0 = NREQ'(1);

    logic [1:0]    state;
    logic [SW-1:0] ptr;
    logic [CW-1:0] wdog;
    logic          grant_found;
    logic [SW-1:0] grant_idx;

    // Round-robin pick. Scan upward from the requester after the last
    // winner and wrap around, so the last winner is checked last. That gives
    // it the lowest priority in the next arbitration.
    always_comb begin
        logic [SW-1:0] idx;
        grant_found = 1'b0;
        grant_idx   = '0;
        idx         = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = SW'((int'(ptr) + k) % NREQ);
            if (!grant_found && req[idx]) begin
                grant_found = 1'b1;
                grant_idx   = idx;
            end
        end
    end

    // Main control sequence. The flow is IDLE -> LAUNCH -> WAIT -> DELIVER.
    // eng_start and ack default low every cycle, so each one is a single-cycle
    // pulse that is raised only on entry to LAUNCH or DELIVER.
    //
    // In WAIT, eng_done is tested before the watchdog limit. A completion that
    // lands in the same cycle as the limit therefore still counts as success.
    //
    // eng_sel holds the current grant for the whole transfer. The ack decode
    // and the pointer update both read it, so no separate grant register is
    // needed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ptr        <= SW'(NREQ - 1);
            wdog       <= '0;
            ack        <= '0;
            rd_data    <= '0;
            err        <= 1'b0;
            eng_start  <= 1'b0;
            eng_sel    <= '0;
            eng_scaler <= '0;
            sched_busy <= 1'b0;
        end else begin
            eng_start <= 1'b0;
            ack       <= '0;
            case (state)
                IDLE: begin
                    if (grant_found && !eng_busy) begin
                        eng_sel    <= grant_idx;
                        eng_scaler <= scaler_cfg[int'(grant_idx)*W +: W];
                        eng_start  <= 1'b1;
                        sched_busy <= 1'b1;
                        state      <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    wdog  <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    if (eng_done) begin
                        rd_data <= eng_data;
                        err     <= 1'b0;
                        ack     <= ONE_HOT0 << eng_sel;
                        state   <= DELIVER;
                    end else if (wdog == CW'(TMO)) begin
                        rd_data <= '0;
                        err     <= 1'b1;
                        ack     <= ONE_HOT0 << eng_sel;
                        state   <= DELIVER;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                DELIVER: begin
                    ptr        <= eng_sel;
                    rd_data    <= '0;
                    err        <= 1'b0;
                    sched_busy <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    sched_busy <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_rr_sched.sv
// ---------------------------------------------------------------------------
// tb_spi_rr_sched
//
// Directed scoreboard bench for spi_rr_sched (NREQ=4, W=8, PKG=16, TMO=16).
// The main process drives req/eng_busy/rst_n and queues the grant each
// scenario should produce. A behavioural engine watches eng_start, checks
// the routed index/scaler against the queued grant and replies after a
// programmed delay (or never). It then queues the ack the scheduler must
// answer with. A separate ack monitor pops and compares every ack pulse.
// ---------------------------------------------------------------------------
module tb_spi_rr_sched;

    localparam int NREQ = 4;
    localparam int W    = 8;
    localparam int PKG  = 16;
    localparam int TMO  = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] scaler_cfg;
    logic [NREQ-1:0]   ack;
    logic [PKG-1:0]    rd_data;
    logic              err;
    logic              eng_start;
    logic [1:0]        eng_sel;
    logic [W-1:0]      eng_scaler;
    logic              eng_busy;
    logic              eng_done;
    logic [PKG-1:0]    eng_data;
    logic              sched_busy;

    spi_rr_sched #(.NREQ(NREQ), .W(W), .PKG(PKG), .TMO(TMO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .scaler_cfg (scaler_cfg),
        .ack        (ack),
        .rd_data    (rd_data),
        .err        (err),
        .eng_start  (eng_start),
        .eng_sel    (eng_sel),
        .eng_scaler (eng_scaler),
        .eng_busy   (eng_busy),
        .eng_done   (eng_done),
        .eng_data   (eng_data),
        .sched_busy (sched_busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [1:0] sel;
        logic [7:0] scaler;
    } grant_t;

    typedef struct {
        logic [3:0]  ack;
        logic [15:0] data;
        logic        err;
        int          cycle;
    } resp_t;

    grant_t      grant_q[$];
    resp_t       ack_q[$];
    int          errors      = 0;
    int          checks      = 0;
    int          start_count = 0;
    int          ack_count   = 0;
    int          eng_delay   = 3;
    logic [15:0] eng_word    = 16'h0000;

    // Single comparison point; every counted check goes through here.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] req_val);
        req = req_val;
    endtask

    task automatic expectGrant(input logic [1:0] sel, input logic [7:0] scaler);
        grant_q.push_back('{sel: sel, scaler: scaler});
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_ack"},        32'(ack),        32'h0);
        checkOutput({tag, "_err"},        32'(err),        32'h0);
        checkOutput({tag, "_rd_data"},    32'(rd_data),    32'h0);
        checkOutput({tag, "_eng_start"},  32'(eng_start),  32'h0);
        checkOutput({tag, "_eng_sel"},    32'(eng_sel),    32'h0);
        checkOutput({tag, "_eng_scaler"}, 32'(eng_scaler), 32'h0);
        checkOutput({tag, "_sched_busy"}, 32'(sched_busy), 32'h0);
    endtask

    task automatic waitAcks(input int target, input int budget);
        int n = 0;
        while (ack_count < target && n < budget) begin
            @(negedge clk);
            #2;
            n++;
        end
        if (ack_count < target) begin
            checks++;
            errors++;
            $display("[TB] FAIL ack_wait: got %0d acks, required %0d", ack_count, target);
        end
    endtask

    task automatic waitStarts(input int target, input int budget);
        int n = 0;
        while (start_count < target && n < budget) begin
            @(negedge clk);
            #2;
            n++;
        end
        if (start_count < target) begin
            checks++;
            errors++;
            $display("[TB] FAIL start_wait: got %0d starts, required %0d", start_count, target);
        end
    endtask

    // Behavioural engine. A launch is seen in cycle S. After d cycles it
    // pulses eng_done in cycle S+d, and the ack is due in cycle S+d+1.
    // A negative delay means the engine never answers, so the watchdog ack
    // is due in cycle S+TMO+2 with err set and data zero.
    initial begin
        grant_t g;
        resp_t  r;
        int     d;
        eng_done = 1'b0;
        eng_data = 16'hDEAD;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && eng_start === 1'b1) begin
                start_count++;
                d = eng_delay;
                checkOutput("start_expected", 32'(grant_q.size() != 0), 32'h1);
                if (grant_q.size() != 0) begin
                    g = grant_q.pop_front();
                    checkOutput("eng_sel",    32'(eng_sel),    32'(g.sel));
                    checkOutput("eng_scaler", 32'(eng_scaler), 32'(g.scaler));
                    r.ack = 4'b0001 << g.sel;
                    if (d < 0) begin
                        r.data  = 16'h0000;
                        r.err   = 1'b1;
                        r.cycle = cyc + TMO + 2;
                    end else begin
                        r.data  = eng_word;
                        r.err   = 1'b0;
                        r.cycle = cyc + d + 1;
                    end
                    ack_q.push_back(r);
                end
                if (d > 0) begin
                    repeat (d) @(negedge clk);
                    eng_done = 1'b1;
                    eng_data = eng_word;
                    @(negedge clk);
                    eng_done = 1'b0;
                    eng_data = 16'hDEAD;
                end
            end
        end
    end

    // Ack monitor: every ack pulse must match the oldest queued response.
    initial begin
        resp_t r;
        forever begin
            @(negedge clk);
            if (ack !== 4'b0000) begin
                ack_count++;
                if (ack_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_ack: got ack=0x%0h, required none", ack);
                end else begin
                    r = ack_q.pop_front();
                    checkOutput("ack",       32'(ack),     32'(r.ack));
                    checkOutput("rd_data",   32'(rd_data), 32'(r.data));
                    checkOutput("err",       32'(err),     32'(r.err));
                    checkOutput("ack_cycle", 32'(cyc),     32'(r.cycle));
                end
            end
        end
    end

    initial begin
        int base;
        rst_n      = 1'b0;
        req        = 4'b0000;
        eng_busy   = 1'b0;
        scaler_cfg = {8'h0D, 8'h05, 8'h0B, 8'h0A};

        repeat (2) @(negedge clk);
        checkReset("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Fairness: all requesters held high; ptr starts at 3 so 0 wins first.
        $display("[TB] fairness");
        eng_delay = 3;
        eng_word  = 16'h1357;
        expectGrant(2'd0, 8'h0A);
        expectGrant(2'd1, 8'h0B);
        expectGrant(2'd2, 8'h05);
        expectGrant(2'd3, 8'h0D);
        expectGrant(2'd0, 8'h0A);
        expectGrant(2'd1, 8'h0B);
        applyStimulus(4'b1111);
        waitAcks(6, 200);
        applyStimulus(4'b0000);
        repeat (3) @(negedge clk);

        // Single request, checking request-to-launch latency as well.
        $display("[TB] single request");
        eng_delay = 10;
        eng_word  = 16'hA5C3;
        expectGrant(2'd2, 8'h05);
        applyStimulus(4'b0100);
        @(negedge clk);
        checkOutput("launch_latency", 32'(eng_start), 32'h1);
        waitAcks(7, 100);
        applyStimulus(4'b0000);
        repeat (3) @(negedge clk);

        // Timeout, then eng_busy blocks the next launch.
        $display("[TB] timeout");
        eng_delay = -1;
        expectGrant(2'd0, 8'h0A);
        applyStimulus(4'b0001);
        waitAcks(8, 100);
        eng_busy = 1'b1;
        eng_delay = 4;
        eng_word  = 16'h3C3C;
        applyStimulus(4'b0010);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("no_start_while_busy", 32'(eng_start), 32'h0);
        end
        expectGrant(2'd1, 8'h0B);
        eng_busy = 1'b0;
        waitAcks(9, 100);
        applyStimulus(4'b0000);
        repeat (3) @(negedge clk);

        // eng_done on the very cycle the watchdog reaches TMO: success.
        $display("[TB] done versus timeout");
        eng_delay = TMO + 1;
        eng_word  = 16'h5AA5;
        expectGrant(2'd2, 8'h05);
        applyStimulus(4'b0100);
        waitAcks(10, 100);
        applyStimulus(4'b0000);
        repeat (3) @(negedge clk);

        // req[1] withdrawn mid-WAIT still gets exactly one ack.
        $display("[TB] withdrawn request");
        eng_delay = 8;
        eng_word  = 16'h0F0F;
        base      = start_count;
        expectGrant(2'd1, 8'h0B);
        applyStimulus(4'b0010);
        waitStarts(base + 1, 50);
        repeat (3) @(negedge clk);
        applyStimulus(4'b0000);
        waitAcks(11, 100);
        repeat (3) @(negedge clk);

        // req[3] glitches between edges while req[0] is held: only 0 granted.
        $display("[TB] glitched request");
        eng_delay = 2;
        eng_word  = 16'h1234;
        expectGrant(2'd0, 8'h0A);
        @(negedge clk);
        applyStimulus(4'b1001);
        #2;
        applyStimulus(4'b0001);
        waitAcks(12, 100);
        applyStimulus(4'b0000);
        repeat (3) @(negedge clk);

        // Reset in the middle of WAIT; afterwards ptr is back at NREQ-1.
        $display("[TB] reset mid-wait");
        eng_delay = -1;
        base      = start_count;
        expectGrant(2'd2, 8'h05);
        applyStimulus(4'b0100);
        waitStarts(base + 1, 50);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkReset("midreset");
        ack_q.delete();
        applyStimulus(4'b1000);
        repeat (2) @(negedge clk);
        eng_delay = 5;
        eng_word  = 16'h7E81;
        expectGrant(2'd3, 8'h0D);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("start_after_reset", 32'(eng_start), 32'h1);
        waitAcks(13, 100);
        applyStimulus(4'b0000);
        repeat (5) @(negedge clk);

        checkOutput("grant_queue_empty", 32'(grant_q.size()), 32'h0);
        checkOutput("ack_queue_empty",   32'(ack_q.size()),   32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global safety net so the run always ends on its own.
    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: got no completion, required finish");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
